// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package inst_loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/debounce_pulse.sv
// Two-FF synchroniser, stability counter and rising-edge pulse for a bouncing push button.
module debounce_pulse #(
  parameter int unsigned DB_N = 21
) (
  input  logic clk,
  input  logic Rst,
  input  logic in,
  output logic level,
  output logic press
);

  logic            ff1;
  logic            ff2;
  logic            level_d;
  logic [DB_N-1:0] cnt;

  // Counter saturates at its MSB; the level only follows ff2 once it has been stable that long.
  always_ff @(posedge clk) begin
    if (Rst) begin
      ff1     <= 1'b0;
      ff2     <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      ff1     <= in;
      ff2     <= ff1;
      level_d <= level;
      if (ff1 != ff2) begin
        cnt <= '0;
      end else if (!cnt[DB_N-1]) begin
        cnt <= cnt + DB_N'(1);
      end
      if (cnt[DB_N-1]) begin
        level <= ff2;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/inst_mem_loader.sv
// Assembles 32-bit program words from debounced byte presses and writes them to instruction memory.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned DB_N   = 21,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              Button,
  input  logic [7:0]        Sw,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_din,
  output logic [1:0]        byte_idx,
  output logic [7:0]        LED,
  output logic              full
);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [1:0]          idx_d;
  logic [7:0]          led_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                full_d;
  logic                db_level;
  logic                db_press;

  debounce_pulse #(.DB_N(DB_N)) u_debounce (
    .clk   (clk),
    .Rst   (Rst),
    .in    (Button),
    .level (db_level),
    .press (db_press)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q  <= COLLECT;
      word_q   <= '0;
      byte_idx <= '0;
      LED      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      full     <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      byte_idx <= idx_d;
      LED      <= led_d;
      mem_we   <= we_d;
      mem_addr <= addr_d;
      full     <= full_d;
    end
  end

  // Next state and register updates; the write strobe defaults low so it lasts one cycle.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = byte_idx;
    led_d   = LED;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    full_d  = full;
    unique case (state_q)
      COLLECT: begin
        if (db_press && db_level) begin
          word_d[{byte_idx, 3'b000} +: 8] = Sw;
          led_d = Sw;
          if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
            idx_d   = '0;
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            idx_d = byte_idx + 2'd1;
          end
        end
      end
      WRITE: begin
        if (&mem_addr) begin
          full_d  = 1'b1;
          state_d = FULL;
        end else begin
          addr_d  = mem_addr + ADDR_W'(1);
          state_d = COLLECT;
        end
      end
      FULL: begin
        state_d = FULL;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign mem_din = word_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed and randomized bench for inst_mem_loader against a byte/word-level loader model.
module tb_inst_mem_loader;

  localparam int unsigned DB_N   = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              Rst;
  logic              Button;
  logic [7:0]        Sw;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [1:0]        byte_idx;
  logic [7:0]        LED;
  logic              full;

  inst_mem_loader #(.DB_N(DB_N), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .Button   (Button),
    .Sw       (Sw),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .byte_idx (byte_idx),
    .LED      (LED),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Observed write traffic, collected away from the active edge.
  int          cyc = 0;
  int          last_wr_cyc = -1;
  int          full_rise_cyc = -1;
  int          we_long = 0;
  bit          we_prev = 0;
  bit          full_prev = 0;
  logic [31:0] got_addr_q[$];
  logic [31:0] got_data_q[$];

  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      got_addr_q.push_back(32'(mem_addr));
      got_data_q.push_back(mem_din);
      last_wr_cyc = cyc;
      if (we_prev) we_long++;
    end
    if (full === 1'b1 && !full_prev) full_rise_cyc = cyc;
    we_prev   = (mem_we === 1'b1);
    full_prev = (full === 1'b1);
  end

  // Reference model: bytes of the current word, next address, full flag, last byte, expected writes.
  logic [7:0]  m_bytes[$];
  int          m_addr;
  bit          m_full;
  logic [7:0]  m_led;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_addr = 0;
    m_full = 0;
    m_led  = 8'h00;
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic model_press(input logic [7:0] v);
    if (m_full) return;
    m_led = v;
    m_bytes.push_back(v);
    if (m_bytes.size() == 4) begin
      exp_addr_q.push_back(32'(m_addr));
      exp_data_q.push_back({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
      m_bytes.delete();
      if (m_addr == DEPTH - 1) m_full = 1;
      else m_addr++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".byte_idx"}, 32'(byte_idx), 32'(m_bytes.size()));
    chk({tag, ".led"},      32'(LED),      32'(m_led));
    chk({tag, ".addr"},     32'(mem_addr), 32'(m_addr));
    chk({tag, ".full"},     32'(full),     32'(m_full));
    chk({tag, ".we_idle"},  32'(mem_we),   32'h0);
    chk({tag, ".wr_count"}, 32'(got_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < got_addr_q.size(); i++) begin
      chk({tag, ".wr_addr"}, got_addr_q[i], exp_addr_q[i]);
      chk({tag, ".wr_data"}, got_data_q[i], exp_data_q[i]);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    Rst = 1'b1;
    repeat (n) @(negedge clk);
    Rst = 1'b0;
    got_addr_q.delete();
    got_data_q.delete();
    full_rise_cyc = -1;
    last_wr_cyc   = -1;
    model_reset();
  endtask

  // Short bursts never stay stable long enough to be mistaken for a level change.
  task automatic bounce_to(input logic final_val);
    repeat ($urandom_range(2, 6)) begin
      Button = ~Button;
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    Button = final_val;
  endtask

  task automatic do_press(input logic [7:0] v, input int hold, input bit bounce);
    Sw = v;
    if (bounce) bounce_to(1'b1);
    Button = 1'b1;
    repeat (hold) @(negedge clk);
    if (bounce) bounce_to(1'b0);
    Button = 1'b0;
    repeat (20) @(negedge clk);
    model_press(v);
  endtask

  initial begin
    Rst    = 1'b1;
    Button = 1'b1;
    Sw     = 8'h5C;
    model_reset();

    // Reset held with Button high: nothing latched, all outputs clear.
    repeat (3) @(negedge clk);
    chk("rst.we",   32'(mem_we),   32'h0);
    chk("rst.addr", 32'(mem_addr), 32'h0);
    chk("rst.din",  mem_din,       32'h0);
    chk("rst.idx",  32'(byte_idx), 32'h0);
    chk("rst.led",  32'(LED),      32'h0);
    chk("rst.full", 32'(full),     32'h0);
    Rst = 1'b0;
    got_addr_q.delete();
    got_data_q.delete();
    repeat (11) @(negedge clk);
    chk("lat.edge10.idx", 32'(byte_idx), 32'h0);
    chk("lat.edge10.led", 32'(LED),      32'h0);
    @(negedge clk);
    chk("lat.edge11.idx", 32'(byte_idx), 32'h1);
    chk("lat.edge11.led", 32'(LED),      32'h5C);
    Button = 1'b0;
    repeat (20) @(negedge clk);
    model_press(8'h5C);
    check_state("lat");

    // One complete word.
    do_reset(2);
    do_press(8'h13, 15, 0);
    do_press(8'h00, 15, 0);
    do_press(8'h00, 15, 0);
    do_press(8'h20, 15, 0);
    check_state("word");
    chk("word.din_const", got_data_q.size() > 0 ? got_data_q[0] : 32'hx, 32'h2000_0013);

    // Bounce every 3 cycles, then a clean hold and release.
    do_reset(1);
    Sw = 8'hA5;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) Button = ~Button;
      @(negedge clk);
    end
    Button = 1'b1;
    repeat (50) @(negedge clk);
    Button = 1'b0;
    repeat (50) @(negedge clk);
    model_press(8'hA5);
    check_state("bounce");

    // Long hold produces a single byte; release adds nothing.
    Sw = 8'h3E;
    Button = 1'b1;
    repeat (1000) @(negedge clk);
    Button = 1'b0;
    repeat (50) @(negedge clk);
    model_press(8'h3E);
    check_state("hold");

    // Partial word discarded by reset, next word lands at address 0.
    do_reset(1);
    do_press(8'hEE, 14, 0);
    do_press(8'hDD, 14, 0);
    do_reset(1);
    check_state("midrst");
    do_press(8'h01, 14, 0);
    do_press(8'h02, 14, 0);
    do_press(8'h03, 14, 0);
    do_press(8'h04, 14, 0);
    check_state("midrst.word");
    chk("midrst.din_const", got_data_q.size() > 0 ? got_data_q[0] : 32'hx, 32'h0403_0201);

    // Random fill to capacity, then extra presses that must be ignored.
    do_reset(1);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      do_press(8'($urandom), $urandom_range(12, 40), 1'($urandom));
      if (i % 4 == 3) check_state("fill");
    end
    chk("fill.full_timing", 32'(full_rise_cyc), 32'(last_wr_cyc + 1));
    for (int i = 0; i < 2; i++) begin
      do_press(8'($urandom), $urandom_range(12, 40), 1'($urandom));
      check_state("after_full");
    end
    chk("we_single_cycle", 32'(we_long), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction-memory fetch/display path. An operator loads program words byte by byte from 8 switches, using a push button.
- Each debounced press latches one byte, least-significant byte first.
- Every fourth press issues a single-cycle write of the assembled 32-bit word to the instruction memory write port (we/addr/din). The word address then auto-increments.
- Byte order matches the display path's byte select: byte 0 is [7:0] and byte 3 is [31:24].

Parameters:
- DB_N, 21: debounce counter width. The level must be stable for 2^(DB_N-1) cycles. Benches use DB_N=4 (8 cycles).
- ADDR_W, 6: word-address width. Memory depth is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- Rst  in  1  synchronous active-high reset
- Button  in  1  raw, asynchronous, bouncing press input, active-high
- Sw  in  8  byte value to latch on a press
- mem_we  out  1  memory write strobe, one cycle per completed word
- mem_addr  out  ADDR_W  word address of the current or next write
- mem_din  out  32  assembled word, valid while mem_we=1
- byte_idx  out  2  number of bytes latched into the current word (0-3)
- LED  out  8  echo of the last latched byte
- full  out  1  all 2^ADDR_W words have been written

Behaviour:
- Reset: Rst is synchronous and active-high. Every register clears on a clk edge where Rst=1:
  - sync FFs, debounce counter, debounced level and its delay FF: 0
  - word register, byte_idx, mem_addr, LED, full: 0
  - mem_we: 0; state: COLLECT
- Rst has priority over every other event. A partial word is discarded with no write.
- If mem_we is already high in the cycle Rst is sampled, the memory still samples that write at the same edge. Nothing after it is written.
- Debounce pipeline (edge 0 is the first edge sampling Button=1):
  - FF1 <= Button; FF2 <= FF1.
  - Counter clears when FF1 != FF2. Otherwise it increments while its MSB is 0 and holds once MSB is 1.
  - db_lvl <= FF2 when the counter MSB is 1.
  - press = db_lvl & ~db_lvl_d, a one-cycle pulse. Release produces no pulse.
  - A clean press is latched at edge 3+2^(DB_N-1). With DB_N=4 this is edge 11.
- States COLLECT, WRITE, FULL. Encoding is in the package.
- COLLECT with press:
  - word[8*byte_idx +: 8] <= Sw; LED <= Sw.
  - If byte_idx < 3: byte_idx increments and state stays COLLECT.
  - If byte_idx = 3: byte_idx <= 0, mem_we <= 1, state <= WRITE.
- WRITE (exactly 1 cycle): mem_din and mem_addr are stable.
  - At the next edge mem_we <= 0.
  - If mem_addr = 2^ADDR_W-1: full <= 1, state <= FULL, and mem_addr holds.
  - Otherwise mem_addr increments and state <= COLLECT.
  - A press during WRITE is ignored. This cannot occur with legal debounce settings.
- FULL: presses are ignored, mem_we stays 0, and LED/byte_idx hold. Exit is by Rst only.
- mem_din is the word register, driven continuously.
- mem_addr never wraps. Overflow goes to FULL.

Decomposition:
- Package inst_loader_pkg holds:
  - state typedef (COLLECT/WRITE/FULL)
  - BYTES_PER_WORD=4
  - default ADDR_W
  - the WORD_W=32 constant
- One sub-module, debounce_pulse (params DB_N; ports clk, Rst, in, level, press). It uses the same synchronous active-high Rst.
- FSM, word assembly and address counter stay in the top.

Test Plan:
- Reset: hold Rst for 3 cycles with Button=1 throughout -> all outputs 0 and no press registered. After Rst falls, a press is latched 11 edges later (DB_N=4).
- Word write: 4 clean presses with Sw=0x13,0x00,0x00,0x20 -> exactly one mem_we pulse of 1 cycle, mem_addr=0, mem_din=0x20000013. Afterwards mem_addr=1, byte_idx=0, LED=0x20.
- Bounce: Button toggles every 3 cycles for 40 cycles, then stays high 50 cycles and low 50 cycles, with Sw=0xA5 -> exactly one byte latched, byte_idx=1, LED=0xA5.
- Long hold: Button high 1000 cycles then low -> one byte only; release latches nothing.
- Mid-word reset: 2 presses, then Rst for 1 cycle -> mem_we never asserts and byte_idx=0. The next 4 presses (0x01,0x02,0x03,0x04) write 0x04030201 at address 0.
- Fill: ADDR_W=2, 16 presses -> writes at addresses 0,1,2,3 and full=1 one cycle after the 4th write. A 17th press leaves mem_we=0, mem_addr=3 and LED unchanged.
